// File: rtl/tracker_row_sequencer.sv
// Tracker row sequencer: steps a pattern held in an external row RAM at a latched tempo
// and turns each row into a note code, gate and one-cycle note strobe for the voice.
module tracker_row_sequencer #(
   parameter int ROW_AW = 6,
   parameter int TPR_W  = 16
) (
   input  logic              clk,
   input  logic              rst_active_high,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [TPR_W-1:0]  ticks_per_row,
   input  logic [ROW_AW-1:0] last_row,
   input  logic              sample_tick,
   output logic              row_rd_en,
   output logic [ROW_AW-1:0] row_addr,
   input  logic [15:0]       row_data,
   output logic [6:0]        note_code,
   output logic              gate,
   output logic              note_strobe,
   output logic              playing
);

   typedef enum logic [1:0] {IDLE, FETCH, LATCH, COUNT} state_t;

   localparam logic [6:0] NOTE_MAX = 7'h6B;

   state_t            state_q, state_d;
   logic [TPR_W-1:0]  tpr_q, tpr_d;
   logic [TPR_W-1:0]  tick_cnt_q, tick_cnt_d;
   logic [TPR_W-1:0]  tick_last;
   logic [ROW_AW-1:0] last_row_q, last_row_d;
   logic [ROW_AW-1:0] row_addr_q, row_addr_d;
   logic              loop_q, loop_d;
   logic [6:0]        note_q, note_d;
   logic              gate_q, gate_d;
   logic              strobe_q, strobe_d;
   logic              playing_q, playing_d;
   logic              unused_row_bits;

   assign unused_row_bits = ^row_data[13:7];

   // A zero tempo behaves as one tick per row.
   assign tick_last = (tpr_q == '0) ? '0 : tpr_q - TPR_W'(1);

   always_comb begin
      state_d    = state_q;
      tpr_d      = tpr_q;
      tick_cnt_d = tick_cnt_q;
      last_row_d = last_row_q;
      row_addr_d = row_addr_q;
      loop_d     = loop_q;
      note_d     = note_q;
      gate_d     = gate_q;
      strobe_d   = 1'b0;
      playing_d  = playing_q;

      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               tpr_d      = ticks_per_row;
               last_row_d = last_row;
               loop_d     = loop_en;
               row_addr_d = '0;
               playing_d  = 1'b1;
               state_d    = FETCH;
            end
         end
         FETCH: state_d = LATCH;
         LATCH: begin
            tick_cnt_d = '0;
            state_d    = COUNT;
            // note_on takes priority over note_off; out-of-range notes are dropped.
            if (row_data[15]) begin
               if (row_data[6:0] <= NOTE_MAX) begin
                  note_d   = row_data[6:0];
                  gate_d   = 1'b1;
                  strobe_d = 1'b1;
               end
            end else if (row_data[14]) begin
               gate_d = 1'b0;
            end
         end
         COUNT: begin
            if (sample_tick) begin
               if (tick_cnt_q == tick_last) begin
                  if (row_addr_q < last_row_q) begin
                     row_addr_d = row_addr_q + ROW_AW'(1);
                     state_d    = FETCH;
                  end else if (loop_q) begin
                     row_addr_d = '0;
                     state_d    = FETCH;
                  end else begin
                     row_addr_d = '0;
                     gate_d     = 1'b0;
                     playing_d  = 1'b0;
                     state_d    = IDLE;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TPR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (stop && (state_q != IDLE)) begin
         state_d    = IDLE;
         gate_d     = 1'b0;
         playing_d  = 1'b0;
         row_addr_d = '0;
         strobe_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_active_high) begin
         state_q    <= IDLE;
         tpr_q      <= '0;
         tick_cnt_q <= '0;
         last_row_q <= '0;
         row_addr_q <= '0;
         loop_q     <= 1'b0;
         note_q     <= '0;
         gate_q     <= 1'b0;
         strobe_q   <= 1'b0;
         playing_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tpr_q      <= tpr_d;
         tick_cnt_q <= tick_cnt_d;
         last_row_q <= last_row_d;
         row_addr_q <= row_addr_d;
         loop_q     <= loop_d;
         note_q     <= note_d;
         gate_q     <= gate_d;
         strobe_q   <= strobe_d;
         playing_q  <= playing_d;
      end
   end

   assign row_rd_en   = (state_q == FETCH);
   assign row_addr    = row_addr_q;
   assign note_code   = note_q;
   assign gate        = gate_q;
   assign note_strobe = strobe_q;
   assign playing     = playing_q;

endmodule
